// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel synchronous clock divider.
package clkdiv_pkg;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_DIV       = 65535;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow divisor, registered tick and square output.
// Tick rises D+1 enabled cycles after a period start; pending divisor swaps in only at a boundary.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int                   CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(DEF_DIV)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_div,
  output logic                 pend,
  output logic                 tick,
  output logic                 sq
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] div_act;
  logic [CNT_WIDTH-1:0] div_pend;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      div_act  <= DEFAULT_DIV;
      div_pend <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else begin
      if (clear) begin
        cnt  <= '0;
        sq   <= 1'b0;
        tick <= 1'b0;
        if (pend) begin
          div_act <= div_pend;
          pend    <= 1'b0;
        end
      end else if (enable) begin
        if (cnt == div_act) begin
          cnt  <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
          if (pend) begin
            div_act <= div_pend;
            pend    <= 1'b0;
          end
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      // A write is only accepted while pend is low, so it never races the swap above.
      if (wr) begin
        div_pend <= wr_div;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel synchronous divider producing enable ticks and 50% squares from one clock.
// cfg_ready is low for a channel while its previous divisor write is still pending.
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int CHAN_W      = chan_w(CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_clear,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  sq
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr;

  // Selects beyond CHANNELS stay ready so such writes complete and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr[i] = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(i));

    clkdiv_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (CNT_WIDTH'(DEFAULT_DIV))
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .clear  (sync_clear),
      .wr     (wr[i]),
      .wr_div (cfg_div),
      .pend   (pend[i]),
      .tick   (tick[i]),
      .sq     (sq[i])
    );
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench: period-countdown model for a 5-channel DEFAULT_DIV=3 instance, plus directed checks on a default instance.
module tb_programmable_clock_divider;

  localparam int NCH  = 5;
  localparam int DEFB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d at %0t: got %0d expected %0d", name, ch, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Default-parameter instance (A)
  logic        a_reset = 1'b1, a_enable = 1'b0, a_clear = 1'b0, a_cfg_valid = 1'b0;
  logic        a_cfg_ready;
  logic [1:0]  a_cfg_chan = '0;
  logic [15:0] a_cfg_div = '0;
  logic [3:0]  a_tick, a_sq;

  programmable_clock_divider u_dut_a (
    .clock(clk), .reset(a_reset), .enable(a_enable), .sync_clear(a_clear),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_chan(a_cfg_chan),
    .cfg_div(a_cfg_div), .tick(a_tick), .sq(a_sq)
  );

  // Short-period instance (B), fully modelled
  logic        b_reset = 1'b1, b_enable = 1'b0, b_clear = 1'b0, b_cfg_valid = 1'b0;
  logic        b_cfg_ready;
  logic [2:0]  b_cfg_chan = '0;
  logic [15:0] b_cfg_div = '0;
  logic [NCH-1:0] b_tick, b_sq;

  programmable_clock_divider #(
    .CHANNELS(NCH), .CNT_WIDTH(16), .DEFAULT_DIV(DEFB), .CHAN_W(3)
  ) u_dut_b (
    .clock(clk), .reset(b_reset), .enable(b_enable), .sync_clear(b_clear),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_chan(b_cfg_chan),
    .cfg_div(b_cfg_div), .tick(b_tick), .sq(b_sq)
  );

  // Model: each channel counts down enabled edges left in its period (period = D+1).
  int m_left [NCH];
  int m_per  [NCH];
  int m_pper [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  bit m_sq   [NCH];
  bit m_on = 1'b0;

  function automatic bit m_ready(input logic [2:0] ch);
    if (int'(ch) >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = b_cfg_valid && m_ready(b_cfg_chan);
    if (b_reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = DEFB + 1; m_left[c] = DEFB + 1; m_pper[c] = 1;
        m_pend[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end
      m_on = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (b_clear) begin
          m_tick[c] = 0; m_sq[c] = 0;
          if (m_pend[c]) begin m_per[c] = m_pper[c]; m_pend[c] = 0; end
          m_left[c] = m_per[c];
        end else if (b_enable) begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_tick[c] = 1; m_sq[c] = !m_sq[c];
            if (m_pend[c]) begin m_per[c] = m_pper[c]; m_pend[c] = 0; end
            m_left[c] = m_per[c];
          end else begin
            m_tick[c] = 0;
          end
        end else begin
          m_tick[c] = 0;
        end
      end
      if (acc && int'(b_cfg_chan) < NCH) begin
        m_pper[b_cfg_chan] = int'(b_cfg_div) + 1;
        m_pend[b_cfg_chan] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      for (int c = 0; c < NCH; c++) begin
        chk("b_tick", c, 32'(b_tick[c]), 32'(m_tick[c]));
        chk("b_sq", c, 32'(b_sq[c]), 32'(m_sq[c]));
      end
      chk("b_cfg_ready", int'(b_cfg_chan), 32'(b_cfg_ready), 32'(m_ready(b_cfg_chan)));
    end
  end

  int b_cyc = 0;
  task automatic goto_b(input int t);
    while (b_cyc < t) begin
      step(1);
      b_cyc++;
    end
  endtask

  task automatic run_b();
    step(3);
    chk("b_reset_tick", 0, 32'(b_tick), 32'd0);
    chk("b_reset_sq", 0, 32'(b_sq), 32'd0);
    chk("b_reset_ready", 0, 32'(b_cfg_ready), 32'd1);
    b_reset = 0; b_enable = 1; b_cyc = 0;
    goto_b(4);  chk("lit_tick4", 0, 32'(b_tick[0]), 1); chk("lit_sq4", 0, 32'(b_sq[0]), 1);
    goto_b(5);  chk("lit_tick5", 0, 32'(b_tick[0]), 0);
    goto_b(8);  chk("lit_tick8", 0, 32'(b_tick[0]), 1); chk("lit_sq8", 0, 32'(b_sq[0]), 0);
    goto_b(12); chk("lit_tick12", 0, 32'(b_tick[0]), 1); chk("lit_sq12", 0, 32'(b_sq[0]), 1);
    // Mid-period write of D=1
    goto_b(13); b_cfg_valid = 1; b_cfg_chan = 0; b_cfg_div = 1;
    goto_b(14); b_cfg_valid = 0; chk("lit_ready_pend", 0, 32'(b_cfg_ready), 0);
    goto_b(16); chk("lit_tick16", 0, 32'(b_tick[0]), 1); chk("lit_ready_back", 0, 32'(b_cfg_ready), 1);
    goto_b(18); chk("lit_tick18", 0, 32'(b_tick[0]), 1);
    // Write on the terminal-count cycle is deferred one period
    goto_b(21); b_cfg_valid = 1; b_cfg_div = 3;
    goto_b(22); b_cfg_valid = 0; chk("lit_tick22", 0, 32'(b_tick[0]), 1);
    goto_b(24); chk("lit_tick24", 0, 32'(b_tick[0]), 1);
    goto_b(26); chk("lit_tick26", 0, 32'(b_tick[0]), 0);
    goto_b(28); chk("lit_tick28", 0, 32'(b_tick[0]), 1);
    // Pause with cnt=2
    goto_b(30); b_enable = 0;
    goto_b(35); chk("lit_hold_tick", 0, 32'(b_tick[0]), 0); chk("lit_hold_sq", 0, 32'(b_sq[0]), 1);
    goto_b(40); b_enable = 1;
    goto_b(41); chk("lit_resume41", 0, 32'(b_tick[0]), 0);
    goto_b(42); chk("lit_resume42", 0, 32'(b_tick[0]), 1); chk("lit_sq42", 0, 32'(b_sq[0]), 0);
    // Program ch0=2, ch1=4, then clear with a concurrent ch2 write
    goto_b(43); b_cfg_valid = 1; b_cfg_chan = 0; b_cfg_div = 2;
    goto_b(44); b_cfg_chan = 1; b_cfg_div = 4;
    goto_b(45); b_cfg_chan = 2; b_cfg_div = 5; b_clear = 1;
    goto_b(46); b_cfg_valid = 0; b_clear = 0;
    chk("lit_clr_sq0", 0, 32'(b_sq[0]), 0); chk("lit_clr_sq1", 1, 32'(b_sq[1]), 0);
    chk("lit_clr_tick0", 0, 32'(b_tick[0]), 0); chk("lit_clr_ready2", 2, 32'(b_cfg_ready), 0);
    goto_b(49); chk("lit_clr_first0", 0, 32'(b_tick[0]), 1);
    goto_b(51); chk("lit_clr_first1", 1, 32'(b_tick[1]), 1);
    // D=0 on ch1
    goto_b(52); b_cfg_valid = 1; b_cfg_chan = 1; b_cfg_div = 0;
    goto_b(53); b_cfg_valid = 0;
    goto_b(57); chk("lit_d0_tick57", 1, 32'(b_tick[1]), 1); chk("lit_d0_sq57", 1, 32'(b_sq[1]), 1);
    goto_b(58); chk("lit_d0_tick58", 1, 32'(b_tick[1]), 1); chk("lit_d0_sq58", 1, 32'(b_sq[1]), 0);
    // Out-of-range channel
    goto_b(60); b_cfg_valid = 1; b_cfg_chan = 5; b_cfg_div = 9;
    #1 chk("lit_oor_ready", 5, 32'(b_cfg_ready), 1);
    goto_b(61); b_cfg_valid = 0; b_cfg_chan = 0;
    // Reset while a write is pending
    goto_b(62); b_cfg_valid = 1; b_cfg_chan = 0; b_cfg_div = 7;
    goto_b(63); b_cfg_valid = 0; b_reset = 1;
    goto_b(65); b_reset = 0; b_cyc = 0;
    chk("lit_rst_ready", 0, 32'(b_cfg_ready), 1);
    goto_b(4); chk("lit_rst_tick0", 0, 32'(b_tick[0]), 1); chk("lit_rst_tick1", 1, 32'(b_tick[1]), 1);
    goto_b(8); chk("lit_rst_tick0_8", 0, 32'(b_tick[0]), 1);
    goto_b(10);
  endtask

  task automatic run_a();
    int ticks;
    int sqs;
    ticks = 0;
    sqs = 0;
    step(3);
    a_reset = 0; a_enable = 1; a_cfg_valid = 1; a_cfg_chan = 0; a_cfg_div = 3;
    step(1);
    a_cfg_valid = 0;
    chk("a_ready_pend", 0, 32'(a_cfg_ready), 0);
    if (a_tick[0]) ticks++;
    if (a_sq[0]) sqs++;
    for (int i = 2; i <= 65535; i++) begin
      step(1);
      if (a_tick[0]) ticks++;
      if (a_sq[0]) sqs++;
    end
    chk("a_early_ticks", 0, 32'(ticks), 0);
    chk("a_early_sq", 0, 32'(sqs), 0);
    step(1); // cycle 65536
    chk("a_tick65536", 0, 32'(a_tick[0]), 1);
    chk("a_sq65536", 0, 32'(a_sq[0]), 1);
    chk("a_ready65536", 0, 32'(a_cfg_ready), 1);
    step(1);
    chk("a_tick65537", 0, 32'(a_tick[0]), 0);
    step(3);
    chk("a_tick65540", 0, 32'(a_tick[0]), 1);
    chk("a_sq65540", 0, 32'(a_sq[0]), 0);
    step(4);
    chk("a_tick65544", 0, 32'(a_tick[0]), 1);
    chk("a_sq65544", 0, 32'(a_sq[0]), 1);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
